// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared op encodings, FSM state type and access-fault helper for
//          the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0]  OP_LW = 2'b00;
    localparam logic [1:0]  OP_SW = 2'b01;
    localparam logic [1:0]  OP_LB = 2'b10;
    localparam logic [1:0]  OP_SB = 2'b11;

    localparam logic [15:0] MEM_TOP_DEFAULT = 16'd10000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } lsu_state_t;

    // Word ops must be even; every op must keep its whole word below the top.
    function automatic logic lsu_access_fault(input logic [1:0]  op,
                                              input logic [15:0] addr,
                                              input logic [15:0] top);
        return ((addr | 16'h0001) > top) ||
               (((op == OP_LW) || (op == OP_SW)) && addr[0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module : load_store_unit_if
// Brief  : Pipeline request/response and data-memory port bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_fault;

    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // master: the LSU itself (initiator toward memory, responder to the pipe)
    modport master (
        input  req_valid, req_op, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );

    // slave: the pipeline plus data memory surrounding the LSU
    modport slave (
        output req_valid, req_op, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/load_store_unit_byte_lane.sv
// ============================================================================
// Module : lsu_byte_lane
// Brief  : Byte-lane select/extend for LB and lane merge for SB.
//          Lane 0 (even address) is [15:8], lane 1 (odd) is [7:0].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_byte_lane (
    input  wire logic [15:0] i_word,
    input  wire logic        i_lane,
    input  wire logic [7:0]  i_byte,
    input  wire logic        i_zero_ext,
    output logic      [15:0] o_load_ext,
    output logic      [15:0] o_store_word
);

    logic [7:0] w_sel;

    assign w_sel        = i_lane ? i_word[7:0] : i_word[15:8];
    assign o_load_ext   = i_zero_ext ? {8'h00, w_sel} : {{8{w_sel[7]}}, w_sel};
    assign o_store_word = i_lane ? {i_word[15:8], i_byte} : {i_byte, i_word[7:0]};

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : MEM-stage load/store initiator; byte stores done as read-modify-
//          write over a 16-bit-only memory write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [15:0] MEM_TOP = MEM_TOP_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    load_store_unit_if.master  bus
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic [1:0]  r_op;
    logic        r_unsigned;
    logic        r_lane;
    logic [7:0]  r_wbyte;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_fault;
    logic [15:0] r_rsp_data;
    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;

    logic        w_accept;
    logic        w_fault;
    logic [15:0] w_load_ext;
    logic [15:0] w_store_word;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
    assign w_fault  = lsu_access_fault(bus.req_op, bus.req_addr, MEM_TOP);

    lsu_byte_lane u_byte_lane (
        .i_word       (bus.mem_rdata),
        .i_lane       (r_lane),
        .i_byte       (r_wbyte),
        .i_zero_ext   (r_unsigned),
        .o_load_ext   (w_load_ext),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_fault) begin
                        w_state_nxt = ST_FAULT;
                    end else if (bus.req_op == OP_SW) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  w_state_nxt = (r_op == OP_SB) ? ST_WRITE : ST_RESP;
            ST_WRITE: w_state_nxt = ST_RESP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Every port output is registered from the next state so it lines up
    // with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_LW;
            r_unsigned  <= 1'b0;
            r_lane      <= 1'b0;
            r_wbyte     <= 8'h00;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_mem_ren   <= (w_state_nxt == ST_READ);
            r_mem_wen   <= (w_state_nxt == ST_WRITE);
            r_rsp_valid <= (w_state_nxt == ST_RESP) || (w_state_nxt == ST_FAULT);
            r_rsp_fault <= (w_state_nxt == ST_FAULT);

            if (w_accept) begin
                r_op       <= bus.req_op;
                r_unsigned <= bus.req_unsigned;
                r_lane     <= bus.req_addr[0];
                r_wbyte    <= bus.req_wdata[7:0];
                if (!w_fault) begin
                    r_mem_addr <= {bus.req_addr[15:1], 1'b0};
                end
            end

            // SW writes straight from the request; SB merges into the word just read.
            if (w_state_nxt == ST_WRITE) begin
                r_mem_wdata <= (r_state == ST_IDLE) ? bus.req_wdata : w_store_word;
            end

            if (w_state_nxt == ST_FAULT) begin
                r_rsp_data <= 16'h0000;
            end else if (w_state_nxt == ST_RESP) begin
                if (r_state != ST_READ) begin
                    r_rsp_data <= 16'h0000;
                end else if (r_op == OP_LW) begin
                    r_rsp_data <= bus.mem_rdata;
                end else begin
                    r_rsp_data <= w_load_ext;
                end
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.mem_ren   = r_mem_ren;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Self-checking bench: directed cases then random requests against
//          a word-array reference memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    localparam logic [15:0] C_TOP = 16'd10000;
    localparam int          C_WORDS = 8192;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_TOP(C_TOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem     [0:C_WORDS-1];
    logic [15:0] ref_mem [0:C_WORDS-1];
    logic        pre_fill;
    logic        pre_we;
    logic [12:0] pre_idx;
    logic [15:0] pre_data;

    function automatic logic [15:0] fill_word(input int i);
        logic [15:0] v;
        v = i[15:0];
        return (v * 16'h9E37) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (pre_fill) begin
            for (int i = 0; i < C_WORDS; i++) mem[i] <= fill_word(i);
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[13:1]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_ren ? mem[bus.mem_addr[13:1]] : 16'h0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] addr, input logic [15:0] data);
        pre_we   = 1'b1;
        pre_idx  = addr[13:1];
        pre_data = data;
        ref_mem[addr[13:1]] = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request and check every cycle until the response, from the
    // reference memory and the documented latency of each op.
    task automatic do_req(input logic [1:0] op, input logic uns,
                          input logic [15:0] addr, input logic [15:0] wd);
        int          guard;
        int          n;
        int          sh;
        logic        flt;
        logic        exp_ren;
        logic        exp_wen;
        logic [15:0] w;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic [15:0] new_w;

        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", {15'd0, bus.req_ready}, 16'd1);

        flt = ((int'(addr) | 1) > int'(C_TOP)) ||
              ((op == OP_LW || op == OP_SW) && (addr % 2 == 1));
        w   = ref_mem[addr[13:1]];
        sh  = (addr % 2 == 1) ? 0 : 8;
        b   = 8'((w >> sh) & 16'h00FF);
        new_w = (w & ~(16'h00FF << sh)) | (16'(wd[7:0]) << sh);
        if (flt || op == OP_SW || op == OP_SB) exp_data = 16'h0000;
        else if (op == OP_LW)                  exp_data = w;
        else if (uns)                          exp_data = {8'h00, b};
        else                                   exp_data = {{8{b[7]}}, b};
        n = flt ? 1 : ((op == OP_SB) ? 3 : 2);

        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;

        for (int k = 1; k <= n; k++) begin
            exp_ren = !flt && (k == 1) && (op != OP_SW);
            exp_wen = !flt && (((op == OP_SW) && (k == 1)) || ((op == OP_SB) && (k == 2)));
            check("mem_ren",   {15'd0, bus.mem_ren},   {15'd0, exp_ren});
            check("mem_wen",   {15'd0, bus.mem_wen},   {15'd0, exp_wen});
            check("rsp_valid", {15'd0, bus.rsp_valid}, {15'd0, (k == n)});
            check("busy_ready", {15'd0, bus.req_ready}, 16'd0);
            if (exp_ren || exp_wen) check("mem_addr", bus.mem_addr, addr & 16'hFFFE);
            if (exp_wen) check("mem_wdata", bus.mem_wdata, (op == OP_SW) ? wd : new_w);
            if (k == n) begin
                check("rsp_fault", {15'd0, bus.rsp_fault}, {15'd0, flt});
                check("rsp_data",  bus.rsp_data, exp_data);
            end
            @(posedge clk); #1;
        end
        check("ready_after", {15'd0, bus.req_ready}, 16'd1);
        check("valid_after", {15'd0, bus.rsp_valid}, 16'd0);

        if (!flt && op == OP_SW) ref_mem[addr[13:1]] = wd;
        if (!flt && op == OP_SB) ref_mem[addr[13:1]] = new_w;
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] addr;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        pre_fill = 1'b0;
        pre_we   = 1'b0;
        pre_idx  = '0;
        pre_data = '0;
        bus.req_valid    = 1'b0;
        bus.req_op       = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 16'h0000;
        bus.req_wdata    = 16'h0000;

        #2;
        check("rst_ready",     {15'd0, bus.req_ready}, 16'd1);
        check("rst_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
        check("rst_rsp_fault", {15'd0, bus.rsp_fault}, 16'd0);
        check("rst_rsp_data",  bus.rsp_data,  16'h0000);
        check("rst_mem_ren",   {15'd0, bus.mem_ren}, 16'd0);
        check("rst_mem_wen",   {15'd0, bus.mem_wen}, 16'd0);
        check("rst_mem_addr",  bus.mem_addr,  16'h0000);
        check("rst_mem_wdata", bus.mem_wdata, 16'h0000);

        for (int i = 0; i < C_WORDS; i++) ref_mem[i] = fill_word(i);
        pre_fill = 1'b1;
        @(posedge clk); #1;
        pre_fill = 1'b0;
        rst = 1'b0;

        poke(16'h0004, 16'h1234);
        do_req(OP_LW, 1'b0, 16'h0004, 16'h0000);
        do_req(OP_SW, 1'b0, 16'h0010, 16'hBEEF);
        do_req(OP_LW, 1'b0, 16'h0010, 16'h0000);
        poke(16'h0006, 16'hDE80);
        do_req(OP_LB, 1'b0, 16'h0007, 16'h0000);
        do_req(OP_LB, 1'b1, 16'h0007, 16'h0000);
        do_req(OP_LB, 1'b0, 16'h0006, 16'h0000);
        poke(16'h0008, 16'hBEEF);
        do_req(OP_SB, 1'b0, 16'h0009, 16'h00AA);
        check("sb_mem_word", mem[4], 16'hBEAA);
        do_req(OP_LW, 1'b0, 16'h0003, 16'h0000);
        do_req(OP_SW, 1'b0, 16'h2712, 16'h1111);
        do_req(OP_LB, 1'b0, 16'h2710, 16'h0000);
        do_req(OP_LB, 1'b1, 16'h270F, 16'h0000);
        do_req(OP_SB, 1'b0, 16'h2710, 16'h0077);

        // Reset during the SB read cycle must abort without a write or response.
        poke(16'h0008, 16'hBEEF);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = 16'h0009;
        bus.req_wdata = 16'h0055;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstmid_ren_before", {15'd0, bus.mem_ren}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_ren",   {15'd0, bus.mem_ren},   16'd0);
        check("rstmid_wen",   {15'd0, bus.mem_wen},   16'd0);
        check("rstmid_ready", {15'd0, bus.req_ready}, 16'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstmid_no_wen",   {15'd0, bus.mem_wen},   16'd0);
            check("rstmid_no_rsp",   {15'd0, bus.rsp_valid}, 16'd0);
            check("rstmid_ready_on", {15'd0, bus.req_ready}, 16'd1);
        end
        check("rstmid_mem_word", mem[4], 16'hBEEF);
        do_req(OP_LW, 1'b0, 16'h0008, 16'h0000);

        for (int r = 0; r < 80; r++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       addr = 16'($urandom_range(9990, 10020));
                1, 2, 3: addr = 16'($urandom_range(0, 31));
                default: addr = 16'($urandom_range(0, 10000));
            endcase
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 5) != 0) addr[0] = 1'b0;
            do_req(op, 1'($urandom_range(0, 1)), addr, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
